// File: rtl/relay_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : relay_reg_pkg
// Brief   : Shared types, constants and helpers for the relay register bank.
// Revision: 1.0  initial release
// ============================================================================
package relay_reg_pkg;

  // Width of the relay settle counter (SETTLE is limited to 0..15)
  localparam int CNT_W = 4;
  // Widest load-strobe vector the one-hot decoder accepts (NREG <= 16)
  localparam int MAX_NREG = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LATCH  = 2'd2
  } ld_state_e;

  typedef struct packed {
    logic       valid;  // exactly one bit of the vector was set
    logic [3:0] idx;    // position of that bit
  } onehot_t;

  // Decode a strobe vector into a register index; valid only when one-hot
  function automatic onehot_t onehot_idx(input logic [MAX_NREG-1:0] vec);
    onehot_t r;
    int      n;
    r = '0;
    n = 0;
    for (int i = 0; i < MAX_NREG; i++) begin
      if (vec[i]) begin
        n     = n + 1;
        r.idx = 4'(i);
      end
    end
    r.valid = (n == 1);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/relay_settle_timer.sv
`default_nettype none
// ============================================================================
// Module  : relay_settle_timer
// Brief   : Loadable down-counter timing the relay settle interval; done is
//           high whenever the count has reached zero.
// Revision: 1.0  initial release
// ============================================================================
module relay_settle_timer
  import relay_reg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the count saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/relay_reg_bank.sv
`default_nettype none
// ============================================================================
// Module  : relay_reg_bank
// Brief   : Bank of NREG bus registers with relay settle load timing, a
//           registered wired-OR read bus and front-panel LED mirrors.
//           Optional feature macro: RELAY_REG_PARITY_EN (per-register even
//           parity with registered par_err output).
// Revision: 1.0  initial release
// ============================================================================
module relay_reg_bank
  import relay_reg_pkg::*;
#(
  parameter int                WIDTH   = 8,
  parameter int                NREG    = 4,
  parameter int                SETTLE  = 2,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREG-1:0]       ld,
  input  logic [NREG-1:0]       sel,
  input  logic [WIDTH-1:0]      data_in,
  output logic [WIDTH-1:0]      data_out,
  output logic                  data_oe,
  output logic [NREG*WIDTH-1:0] reg_q,
  output logic                  busy,
  output logic [NREG-1:0]       led_ld,
  output logic [NREG-1:0]       led_sel,
  output logic                  err
`ifdef RELAY_REG_PARITY_EN
  ,
  output logic                  par_err
`endif
);

  // Counter preload: SETTLE-1, clamped for the SETTLE==0 build where the
  // timer is never consulted
  localparam int               SETTLE_M1     = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [CNT_W-1:0] c_settle_init = CNT_W'(SETTLE_M1);

  relay_reg_pkg::ld_state_e state_q, state_d;
  logic [3:0]               idx_q, idx_d;
  logic [WIDTH-1:0]         stage_q, stage_d;
  logic [WIDTH-1:0]         regs_q [NREG];
  logic [WIDTH-1:0]         regs_d [NREG];
  logic [WIDTH-1:0]         data_out_q, data_out_d;
  logic                     data_oe_q, data_oe_d;
  logic [NREG-1:0]          led_sel_q, led_sel_d;
  logic                     err_q, err_d;

  logic [MAX_NREG-1:0]      ld_ext;
  onehot_t                  ld_oh;
  logic                     ld_any;
  logic                     busy_w;
  logic                     tmr_load;
  logic                     tmr_dec;
  logic                     tmr_done;

`ifdef RELAY_REG_PARITY_EN
  logic [NREG-1:0]          par_q, par_d;
  logic                     par_err_q, par_err_d;
`endif

  relay_settle_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (c_settle_init),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  // Widen the strobes to the decoder width and classify them
  always_comb begin
    ld_ext = '0;
    for (int i = 0; i < NREG; i++) begin
      ld_ext[i] = ld[i];
    end
    ld_oh  = onehot_idx(ld_ext);
    ld_any = |ld;
    busy_w = (state_q != relay_reg_pkg::IDLE);
  end

  // Load FSM: capture into staging, wait out the relay, then latch
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    stage_d  = stage_q;
    regs_d   = regs_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
`ifdef RELAY_REG_PARITY_EN
    par_d    = par_q;
`endif
    // Malformed strobes or any strobe during a load are dropped with an error
    err_d    = ld_any && (!ld_oh.valid || busy_w);

    case (state_q)
      relay_reg_pkg::IDLE: begin
        if (ld_any && ld_oh.valid) begin
          idx_d    = ld_oh.idx;
          stage_d  = data_in;
          tmr_load = 1'b1;
          state_d  = (SETTLE == 0) ? relay_reg_pkg::LATCH : relay_reg_pkg::SETTLE;
        end
      end
      relay_reg_pkg::SETTLE: begin
        tmr_dec = 1'b1;
        if (tmr_done) begin
          state_d = relay_reg_pkg::LATCH;
        end
      end
      relay_reg_pkg::LATCH: begin
        for (int i = 0; i < NREG; i++) begin
          if (idx_q == 4'(i)) begin
            regs_d[i] = stage_q;
`ifdef RELAY_REG_PARITY_EN
            par_d[i]  = ^stage_q;
`endif
          end
        end
        state_d = relay_reg_pkg::IDLE;
      end
      default: begin
        state_d = relay_reg_pkg::IDLE;
      end
    endcase
  end

  // Read path: wired-OR of every selected register, one cycle of latency
  always_comb begin
    data_out_d = '0;
    for (int i = 0; i < NREG; i++) begin
      if (sel[i]) begin
        data_out_d = data_out_d | regs_q[i];
      end
    end
    data_oe_d = |sel;
    led_sel_d = sel;
`ifdef RELAY_REG_PARITY_EN
    par_err_d = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (sel[i] && (par_q[i] != ^regs_q[i])) begin
        par_err_d = 1'b1;
      end
    end
`endif
  end

  // State registers; reset also aborts any load in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= relay_reg_pkg::IDLE;
      idx_q      <= '0;
      stage_q    <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= RST_VAL;
      end
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      led_sel_q  <= '0;
      err_q      <= 1'b0;
`ifdef RELAY_REG_PARITY_EN
      par_q      <= {NREG{^RST_VAL}};
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      stage_q    <= stage_d;
      regs_q     <= regs_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      led_sel_q  <= led_sel_d;
      err_q      <= err_d;
`ifdef RELAY_REG_PARITY_EN
      par_q      <= par_d;
      par_err_q  <= par_err_d;
`endif
    end
  end

  // Load LED shows the target register for as long as the load is in flight
  always_comb begin
    led_ld = '0;
    for (int i = 0; i < NREG; i++) begin
      led_ld[i] = busy_w && (idx_q == 4'(i));
    end
  end

  generate
    for (genvar g = 0; g < NREG; g++) begin : g_flat
      assign reg_q[g*WIDTH +: WIDTH] = regs_q[g];
    end
  endgenerate

  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;
  assign led_sel  = led_sel_q;
  assign err      = err_q;
  assign busy     = busy_w;
`ifdef RELAY_REG_PARITY_EN
  assign par_err  = par_err_q;
`endif

endmodule
`default_nettype wire
